// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: EX forwarding selects
// and the MDU busy-tracker state encoding.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_busy_ctr.sv
// Tracks the multi-cycle mult/div unit: busy for exactly MDU_LAT cycles after
// the issue edge. A start seen while already waiting is ignored.
module mdu_busy_ctr
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    output logic busy
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] LOAD_C = CW'(MDU_LAT - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(32'd1);
    localparam logic [CW-1:0] ZERO_C = CW'(32'd0);

    mdu_state_e    state_r;
    mdu_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          busy_s;

    // State and countdown registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_RUN;
            cnt_r   <= ZERO_C;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and countdown logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (start) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = LOAD_C;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (cnt_r == ZERO_C) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = ZERO_C;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - ONE_C;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = ZERO_C;
            end
        endcase
    end

    // Busy output decode
    always_comb begin
        busy_s = 1'b0;
        if (state_r == ST_WAIT) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    assign busy = busy_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use / branch / MDU stalls, branch flush and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] wreg_e,
    input  logic [REG_W-1:0] wreg_m,
    input  logic [REG_W-1:0] wreg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             branch_d,
    input  logic             taken_d,
    input  logic             mdu_start_e,
    input  logic             mdu_use_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] R0_C    = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] SAT_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CONE_C  = CNT_W'(32'd1);

    // Register r is produced by a stage that writes a nonzero destination equal to r.
    function automatic logic reg_match(input logic we, input logic [REG_W-1:0] wr,
                                       input logic [REG_W-1:0] r);
        return we && (wr != R0_C) && (wr == r);
    endfunction

    logic             mdu_busy_s;
    logic             lwstall_s;
    logic             brstall_s;
    logic             mdustall_s;
    logic             stall_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;
    logic [CNT_W-1:0] stall_cnt_r;

    mdu_busy_ctr #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk   (clk),
        .clr_n (clr_n),
        .start (mdu_start_e),
        .busy  (mdu_busy_s)
    );

    // EX forwarding selects; the younger MEM result wins over WB
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (reg_match(regwrite_m, wreg_m, rs_e)) begin
            fwd_a_s = FWD_MEM;
        end else if (reg_match(regwrite_w, wreg_w, rs_e)) begin
            fwd_a_s = FWD_WB;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (reg_match(regwrite_m, wreg_m, rt_e)) begin
            fwd_b_s = FWD_MEM;
        end else if (reg_match(regwrite_w, wreg_w, rt_e)) begin
            fwd_b_s = FWD_WB;
        end else begin
            fwd_b_s = FWD_RF;
        end
    end

    // Stall sources: load-use, ID-stage branch compare, MDU result not ready
    always_comb begin
        lwstall_s  = memtoreg_e && (wreg_e != R0_C) && ((wreg_e == rs_d) || (wreg_e == rt_d));
        brstall_s  = branch_d &&
                     ((reg_match(regwrite_e, wreg_e, rs_d) || reg_match(regwrite_e, wreg_e, rt_d)) ||
                      (memtoreg_m && (reg_match(regwrite_m, wreg_m, rs_d) ||
                                      reg_match(regwrite_m, wreg_m, rt_d))));
        mdustall_s = mdu_use_d && (mdu_busy_s || mdu_start_e);
        stall_s    = lwstall_s || brstall_s || mdustall_s;
    end

    // Output drive; everything reads zero while reset is held
    always_comb begin
        if (clr_n) begin
            stall_f = stall_s;
            stall_d = stall_s;
            flush_e = stall_s;
            flush_d = taken_d && !stall_s;
            fwd_a_e = fwd_a_s;
            fwd_b_e = fwd_b_s;
            fwd_a_d = reg_match(regwrite_m, wreg_m, rs_d);
            fwd_b_d = reg_match(regwrite_m, wreg_m, rt_d);
        end else begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_e = 1'b0;
            flush_d = 1'b0;
            fwd_a_e = FWD_RF;
            fwd_b_e = FWD_RF;
            fwd_a_d = 1'b0;
            fwd_b_d = 1'b0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_r <= CZERO_C;
        end else if (stall_s && (stall_cnt_r != SAT_C)) begin
            stall_cnt_r <= stall_cnt_r + CONE_C;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mdu_busy  = mdu_busy_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MDU_LAT=4, narrow stall counter
// so saturation is reachable).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       branch_d, taken_d, mdu_start_e, mdu_use_d;
    logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, mdu_busy;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [3:0] stall_cnt;

    int nv = 0;
    int nerr = 0;

    pipe_hazard_ctrl #(.REG_W(5), .MDU_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .clr_n(clr_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .taken_d(taken_d),
        .mdu_start_e(mdu_start_e), .mdu_use_d(mdu_use_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0;
        wreg_e = 5'd0; wreg_m = 5'd0; wreg_w = 5'd0;
        regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        memtoreg_e = 1'b0; memtoreg_m = 1'b0;
        branch_d = 1'b0; taken_d = 1'b0; mdu_start_e = 1'b0; mdu_use_d = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        clr_n = 1'b0;
        clear_inputs;
        tick;
        clr_n = 1'b1;
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        clear_inputs;
        memtoreg_e = 1'b1; wreg_e = 5'd5; rt_d = 5'd5;
        regwrite_m = 1'b1; wreg_m = 5'd8; rs_e = 5'd8; rs_d = 5'd8;
        mdu_start_e = 1'b1; mdu_use_d = 1'b1;
        #2;
        nv++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL rst_stall_f got %b exp 0", stall_f); end
        nv++; if (flush_e !== 1'b0) begin nerr++; $display("FAIL rst_flush_e got %b exp 0", flush_e); end
        nv++; if (fwd_a_e !== 2'b00) begin nerr++; $display("FAIL rst_fwd_a_e got %b exp 00", fwd_a_e); end
        nv++; if (fwd_a_d !== 1'b0) begin nerr++; $display("FAIL rst_fwd_a_d got %b exp 0", fwd_a_d); end
        tick;
        nv++; if (mdu_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", mdu_busy); end
        nv++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
        clear_inputs;
        clr_n = 1'b1;
    endtask

    task automatic test_forward;
        do_reset;
        regwrite_m = 1'b1; wreg_m = 5'd8; rs_e = 5'd8;
        regwrite_w = 1'b1; wreg_w = 5'd8; rt_e = 5'd8;
        #1;
        nv++; if (fwd_a_e !== 2'b10) begin nerr++; $display("FAIL fwd_a_mem got %b exp 10", fwd_a_e); end
        nv++; if (fwd_b_e !== 2'b10) begin nerr++; $display("FAIL fwd_b_memwins got %b exp 10", fwd_b_e); end
        wreg_m = 5'd9;
        #1;
        nv++; if (fwd_b_e !== 2'b01) begin nerr++; $display("FAIL fwd_b_wb got %b exp 01", fwd_b_e); end
        nv++; if (fwd_a_e !== 2'b01) begin nerr++; $display("FAIL fwd_a_wb got %b exp 01", fwd_a_e); end
        rs_d = 5'd9; rt_d = 5'd8;
        #1;
        nv++; if (fwd_a_d !== 1'b1) begin nerr++; $display("FAIL fwd_a_d got %b exp 1", fwd_a_d); end
        nv++; if (fwd_b_d !== 1'b0) begin nerr++; $display("FAIL fwd_b_d got %b exp 0", fwd_b_d); end
        nv++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL fwd_nostall got %b exp 0", stall_f); end
        regwrite_m = 1'b0; regwrite_w = 1'b0;
        #1;
        nv++; if (fwd_a_e !== 2'b00) begin nerr++; $display("FAIL fwd_nowrite got %b exp 00", fwd_a_e); end
        clear_inputs;
    endtask

    task automatic test_zero_reg;
        do_reset;
        regwrite_m = 1'b1; wreg_m = 5'd0; rs_e = 5'd0; rs_d = 5'd0;
        regwrite_w = 1'b1; wreg_w = 5'd0; rt_e = 5'd0;
        memtoreg_e = 1'b1; wreg_e = 5'd0; branch_d = 1'b1; regwrite_e = 1'b1;
        #1;
        nv++; if (fwd_a_e !== 2'b00) begin nerr++; $display("FAIL zero_fwd_a_e got %b exp 00", fwd_a_e); end
        nv++; if (fwd_b_e !== 2'b00) begin nerr++; $display("FAIL zero_fwd_b_e got %b exp 00", fwd_b_e); end
        nv++; if (fwd_a_d !== 1'b0) begin nerr++; $display("FAIL zero_fwd_a_d got %b exp 0", fwd_a_d); end
        nv++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL zero_stall got %b exp 0", stall_f); end
        clear_inputs;
    endtask

    task automatic test_load_use;
        do_reset;
        memtoreg_e = 1'b1; wreg_e = 5'd5; rt_d = 5'd5; rs_d = 5'd2;
        #1;
        nv++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin nerr++; $display("FAIL lu_stall got %b exp 111", {stall_f, stall_d, flush_e}); end
        nv++; if (flush_d !== 1'b0) begin nerr++; $display("FAIL lu_flush_d got %b exp 0", flush_d); end
        nv++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL lu_cnt0 got %0d exp 0", stall_cnt); end
        tick;
        clear_inputs;
        #1;
        nv++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL lu_release got %b exp 0", stall_f); end
        nv++; if (stall_cnt !== 4'd1) begin nerr++; $display("FAIL lu_cnt1 got %0d exp 1", stall_cnt); end
        memtoreg_e = 1'b1; wreg_e = 5'd7; rs_d = 5'd7;
        #1;
        nv++; if (stall_d !== 1'b1) begin nerr++; $display("FAIL lu_rs got %b exp 1", stall_d); end
        memtoreg_e = 1'b0;
        #1;
        nv++; if (stall_d !== 1'b0) begin nerr++; $display("FAIL lu_noload got %b exp 0", stall_d); end
        clear_inputs;
    endtask

    task automatic test_branch;
        do_reset;
        branch_d = 1'b1; taken_d = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd3; rs_d = 5'd3;
        #1;
        nv++; if (stall_d !== 1'b1) begin nerr++; $display("FAIL br_stall got %b exp 1", stall_d); end
        nv++; if (flush_d !== 1'b0) begin nerr++; $display("FAIL br_flush_held got %b exp 0", flush_d); end
        tick;
        regwrite_e = 1'b0;
        #1;
        nv++; if (flush_d !== 1'b1) begin nerr++; $display("FAIL br_flush got %b exp 1", flush_d); end
        nv++; if (stall_d !== 1'b0) begin nerr++; $display("FAIL br_nostall got %b exp 0", stall_d); end
        nv++; if (stall_cnt !== 4'd1) begin nerr++; $display("FAIL br_cnt got %0d exp 1", stall_cnt); end
        taken_d = 1'b0; regwrite_m = 1'b1; wreg_m = 5'd4; rt_d = 5'd4; memtoreg_m = 1'b1;
        #1;
        nv++; if (stall_d !== 1'b1) begin nerr++; $display("FAIL br_memload got %b exp 1", stall_d); end
        memtoreg_m = 1'b0;
        #1;
        nv++; if (stall_d !== 1'b0) begin nerr++; $display("FAIL br_memalu got %b exp 0", stall_d); end
        nv++; if (fwd_b_d !== 1'b1) begin nerr++; $display("FAIL br_fwd_b_d got %b exp 1", fwd_b_d); end
        branch_d = 1'b0; regwrite_e = 1'b1; wreg_e = 5'd3; rs_d = 5'd3;
        #1;
        nv++; if (stall_d !== 1'b0) begin nerr++; $display("FAIL br_nobranch got %b exp 0", stall_d); end
        clear_inputs;
    endtask

    task automatic test_mdu;
        do_reset;
        mdu_start_e = 1'b1; mdu_use_d = 1'b1;
        #1;
        nv++; if (stall_f !== 1'b1) begin nerr++; $display("FAIL mdu_issue_stall got %b exp 1", stall_f); end
        nv++; if (mdu_busy !== 1'b0) begin nerr++; $display("FAIL mdu_issue_busy got %b exp 0", mdu_busy); end
        tick;
        mdu_start_e = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nv++; if ({mdu_busy, stall_f} !== 2'b11) begin nerr++; $display("FAIL mdu_wait%0d got %b exp 11", i, {mdu_busy, stall_f}); end
            tick;
        end
        #1;
        nv++; if ({mdu_busy, stall_f} !== 2'b00) begin nerr++; $display("FAIL mdu_done got %b exp 00", {mdu_busy, stall_f}); end
        nv++; if (stall_cnt !== 4'd5) begin nerr++; $display("FAIL mdu_cnt got %0d exp 5", stall_cnt); end
        clear_inputs;
    endtask

    task automatic test_back_to_back;
        do_reset;
        mdu_start_e = 1'b1;
        tick;
        mdu_start_e = 1'b0;
        tick;
        mdu_start_e = 1'b1;
        tick;
        mdu_start_e = 1'b0;
        #1;
        nv++; if (mdu_busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy3 got %b exp 1", mdu_busy); end
        tick;
        #1;
        nv++; if (mdu_busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy4 got %b exp 1", mdu_busy); end
        tick;
        #1;
        nv++; if (mdu_busy !== 1'b0) begin nerr++; $display("FAIL b2b_noreload got %b exp 0", mdu_busy); end
        nv++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL b2b_cnt got %0d exp 0", stall_cnt); end
        clear_inputs;
    endtask

    task automatic test_reset_mid_wait;
        do_reset;
        mdu_start_e = 1'b1; mdu_use_d = 1'b1;
        tick;
        mdu_start_e = 1'b0;
        tick;
        #1;
        nv++; if (mdu_busy !== 1'b1) begin nerr++; $display("FAIL rmw_busy got %b exp 1", mdu_busy); end
        clr_n = 1'b0;
        #1;
        nv++; if (mdu_busy !== 1'b0) begin nerr++; $display("FAIL rmw_abort got %b exp 0", mdu_busy); end
        nv++; if (stall_cnt !== 4'd0) begin nerr++; $display("FAIL rmw_cnt got %0d exp 0", stall_cnt); end
        nv++; if ({stall_f, flush_e} !== 2'b00) begin nerr++; $display("FAIL rmw_out got %b exp 00", {stall_f, flush_e}); end
        tick;
        tick;
        clr_n = 1'b1;
        tick;
        #1;
        nv++; if ({mdu_busy, stall_f} !== 2'b00) begin nerr++; $display("FAIL rmw_run got %b exp 00", {mdu_busy, stall_f}); end
        clear_inputs;
    endtask

    task automatic test_saturate;
        do_reset;
        memtoreg_e = 1'b1; wreg_e = 5'd5; rt_d = 5'd5;
        repeat (14) tick;
        #1;
        nv++; if (stall_cnt !== 4'd14) begin nerr++; $display("FAIL sat_14 got %0d exp 14", stall_cnt); end
        repeat (6) tick;
        #1;
        nv++; if (stall_cnt !== 4'd15) begin nerr++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
        nv++; if (stall_f !== 1'b1) begin nerr++; $display("FAIL sat_stall got %b exp 1", stall_f); end
        clear_inputs;
    endtask

    initial begin
        test_reset;
        test_forward;
        test_zero_reg;
        test_load_use;
        test_branch;
        test_mdu;
        test_back_to_back;
        test_reset_mid_wait;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
